// File: rtl/bcd_countdown_pkg.sv
// Shared BCD digit types and constants for the countdown timer.
// Also holds the control FSM state encoding.
package bcd_countdown_pkg;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic bcd_digit_t bcd_clamp(
    input bcd_digit_t d
  );
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_decrementer.sv
// One BCD digit of the borrow-ripple decrement chain.
// Invalid codes are treated as 9 before decrementing.
import bcd_countdown_pkg::*;

module bcd_decrementer (
  input  logic [3:0] bcd_in,
  input  logic       borrow_in,
  output logic [3:0] bcd_out,
  output logic       borrow_out
);

  bcd_digit_t d;

  assign d = bcd_clamp(bcd_in);

  // digit minus borrow, wrapping 0 to 9 with borrow out
  always_comb begin
    bcd_out    = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == BCD_ZERO) begin
        bcd_out    = BCD_NINE;
        borrow_out = 1'b1;
      end else begin
        bcd_out = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Packed-BCD countdown timer with prescaler, saturating at zero.
// Pulses done for one cycle when a decrement reaches zero.
import bcd_countdown_pkg::*;

module bcd_countdown #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50_000_000,
  parameter int PRESCALE_W = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [PRESCALE_W-1:0] PS_LAST =
    PRESCALE_W'(PRESCALE - 1);

  logic [W-1:0]          count;
  logic [W-1:0]          dec;
  logic [W-1:0]          clamped;
  logic [DIGITS:0]       borrow;
  logic [PRESCALE_W-1:0] pre;
  state_t                state;
  state_t                state_n;
  logic                  tick;
  logic                  adv;
  logic                  last;

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_decrementer u_dec (
      .bcd_in     (count[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .bcd_out    (dec[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
    assign clamped[4*g +: 4] =
      bcd_clamp(load_value[4*g +: 4]);
  end

  assign tick    = (state == ST_RUN) && (pre == PS_LAST);
  assign last    = (dec == '0);
  assign zero    = (count == '0);
  assign running = (state == ST_RUN);
  assign bcd_out = count;

  // control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // next state and decrement enable; load beats stop beats start
  always_comb begin
    state_n = state;
    adv     = 1'b0;
    if (load || stop) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !zero) state_n = ST_RUN;
        end
        ST_RUN: begin
          // a borrow out of the top digit would mean a wrap
          adv = tick && !borrow[DIGITS];
          if (adv && last) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // count, prescaler and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      pre   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= clamped;
        pre   <= '0;
      end else if (!stop && state == ST_RUN) begin
        pre <= tick ? '0 : pre + PRESCALE_W'(1);
        if (adv) count <= dec;
        if (adv && last) done <= 1'b1;
      end
    end
  end

endmodule
